hazard_forwarding_controller: RTL and testbench
===============================================

HAZARD_FORWARDING_CONTROLLER -- requirements
Module: hazard_forwarding_controller

Interface
REQ-001 SHALL have input clk, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs ID_Bit19_16, ID_Bit3_0, ID_Bit15_12, 4 bits each: Rn, Rm and Rd/store-source register of the instruction in ID.
REQ-004 SHALL have inputs ID_use_rn, ID_use_rm, ID_use_rd, 1 bit each: the corresponding ID register is actually read.
REQ-005 SHALL have inputs EX_Bit15_12, MEM_Bit15_12, WB_Bit15_12, 4 bits each: destination register per stage.
REQ-006 SHALL have inputs EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable, EX_load_instr, MEM_load_instr, 1 bit each.
REQ-007 SHALL have input branch_taken, 1 bit: ID branch resolved taken; input mem_busy, 1 bit: data RAM not ready; input clr_count, 1 bit: synchronous counter clear.
REQ-008 SHALL have outputs MUX1_signal, MUX2_signal, MUX3_signal, 2 bits each: operand source select for Rn, Rm, Rd.
REQ-009 SHALL have outputs PC_RF_ld, IF_ID_Load, pipe_en, MUXControlUnit_signal (1 = inject NOP into ID/EX), IF_ID_flush, 1 bit each.
REQ-010 SHALL have output stall_count, 16 bits: saturating count of stalled cycles.

Function
REQ-011 SHALL encode mux selects as 00 register file, 01 EX ALU result (A_O), 10 MEM result (M_O), 11 WB write data (PW).
REQ-012 SHALL, per source, select 01 if EX_RF_Enable & !EX_load_instr & match; else 10 if MEM_RF_Enable & !MEM_load_instr & match; else 11 if WB_RF_Enable & match; else 00 (nearest stage wins).
REQ-013 SHALL select 00 when the source register is 4'hF or its use flag is 0.
REQ-014 SHALL define load-use hazard LU_EX: EX_load_instr & EX_RF_Enable & used-source match with EX_Bit15_12; LU_MEM: same against MEM stage.
REQ-015 SHALL implement FSM states RUN, LU_STALL, FREEZE.
REQ-016 SHALL, in RUN with LU_EX, stall (PC_RF_ld=0, IF_ID_Load=0, MUXControlUnit_signal=1, pipe_en=1) and go to LU_STALL.
REQ-017 SHALL, in RUN with LU_MEM and no LU_EX, stall one cycle and remain in RUN.
REQ-018 SHALL, in LU_STALL, stall unconditionally one cycle and return to RUN; consumer then takes WB forward (11).
REQ-019 SHALL, on mem_busy=1 in any state, deassert PC_RF_ld, IF_ID_Load, pipe_en, hold MUXControlUnit_signal=0, enter FREEZE and save return state (RUN or LU_STALL).
REQ-020 SHALL, in FREEZE with mem_busy=0, resume the saved state with no lost or repeated stall cycle.
REQ-021 SHALL apply priority mem_busy > load-use stall > branch_taken.
REQ-022 SHALL, on branch_taken in RUN with no stall, assert IF_ID_flush=1 for that cycle, PC_RF_ld=1, IF_ID_Load=1; branch_taken during stall is ignored until ID is re-evaluated.
REQ-023 SHALL otherwise output PC_RF_ld=1, IF_ID_Load=1, pipe_en=1, MUXControlUnit_signal=0, IF_ID_flush=0.
REQ-024 SHALL increment stall_count every cycle IF_ID_Load=0, saturating at 16'hFFFF; clr_count has priority over increment.

Reset
REQ-025 SHALL, while rst_n=0, force state RUN, saved state RUN, stall_count 0, PC_RF_ld=0, IF_ID_Load=0, pipe_en=0, MUXControlUnit_signal=1, IF_ID_flush=0, MUX*_signal=00.
REQ-026 SHALL, on rst_n rising mid-stall or mid-freeze, start in RUN with no residual stall.

Structure
REQ-027 SHALL place mux encodings, FSM state encodings and PC register constant (4'hF) in package pipe_ctrl_pkg.
REQ-028 SHALL instantiate sub-module forward_select three times (Rn, Rm, Rd); FSM and counter in top.

Verification
REQ-029 ALU r5 in EX, ID reads Rn=r5 -> MUX1_signal=01; same r5 also in MEM -> still 01.
REQ-030 Load r2 in EX, ID reads Rm=r2 -> 2 cycles IF_ID_Load=0 and NOP injected, 3rd cycle MUX2_signal=11, stall_count=2.
REQ-031 Load-use stall cycle 1 with mem_busy=1 for 3 cycles -> pipe_en=0 for 3 cycles, then exactly 1 remaining stall cycle, stall_count=5.
REQ-032 branch_taken=1 in RUN -> IF_ID_flush=1 one cycle; with LU_EX simultaneous -> IF_ID_flush=0, stall taken.
REQ-033 ID reads r15 with WB writing r15 -> select 00; stall_count preset to 16'hFFFF with stall -> stays 16'hFFFF; clr_count -> 0.
REQ-034 rst_n low during LU_STALL -> all outputs at REQ-025 values asynchronously; after release, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller:
// operand-source selects, controller FSM states and the PC register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_FREEZE   = 2'b10
    } ctrl_state_e;

    localparam logic [3:0]  PC_REG        = 4'hF;
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/forward_select.sv
// Per-source forwarding select plus load-use hazard detection against EX and MEM.
module forward_select
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] src_i,
    input  logic       use_i,
    input  logic [3:0] ex_rd_i,
    input  logic       ex_we_i,
    input  logic       ex_load_i,
    input  logic [3:0] mem_rd_i,
    input  logic       mem_we_i,
    input  logic       mem_load_i,
    input  logic [3:0] wb_rd_i,
    input  logic       wb_we_i,
    output fwd_sel_e   sel_o,
    output logic       lu_ex_o,
    output logic       lu_mem_o
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = use_i && ex_we_i  && (src_i == ex_rd_i);
    assign mem_hit = use_i && mem_we_i && (src_i == mem_rd_i);
    assign wb_hit  = use_i && wb_we_i  && (src_i == wb_rd_i);

    // NOTE: sel_o gets its default first so no path through the block infers a latch.
    always_comb begin
        sel_o = FWD_RF;
        // The PC is never forwarded; its value comes from the fetch side.
        if (src_i != PC_REG) begin
            if (ex_hit && !ex_load_i) begin
                sel_o = FWD_EX;
            end else if (mem_hit && !mem_load_i) begin
                sel_o = FWD_MEM;
            end else if (wb_hit) begin
                sel_o = FWD_WB;
            end
        end
    end

    assign lu_ex_o  = ex_hit  && ex_load_i;
    assign lu_mem_o = mem_hit && mem_load_i;

endmodule

// File: rtl/hazard_forwarding_controller.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, memory freeze,
// branch flush and a saturating stall-cycle counter.
module hazard_forwarding_controller
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ID_Bit19_16,
    input  logic [3:0]  ID_Bit3_0,
    input  logic [3:0]  ID_Bit15_12,
    input  logic        ID_use_rn,
    input  logic        ID_use_rm,
    input  logic        ID_use_rd,
    input  logic [3:0]  EX_Bit15_12,
    input  logic [3:0]  MEM_Bit15_12,
    input  logic [3:0]  WB_Bit15_12,
    input  logic        EX_RF_Enable,
    input  logic        MEM_RF_Enable,
    input  logic        WB_RF_Enable,
    input  logic        EX_load_instr,
    input  logic        MEM_load_instr,
    input  logic        branch_taken,
    input  logic        mem_busy,
    input  logic        clr_count,
    output logic [1:0]  MUX1_signal,
    output logic [1:0]  MUX2_signal,
    output logic [1:0]  MUX3_signal,
    output logic        PC_RF_ld,
    output logic        IF_ID_Load,
    output logic        pipe_en,
    output logic        MUXControlUnit_signal,
    output logic        IF_ID_flush,
    output logic [15:0] stall_count
);

    fwd_sel_e    sel_rn, sel_rm, sel_rd;
    logic        lu_ex_rn, lu_ex_rm, lu_ex_rd;
    logic        lu_mem_rn, lu_mem_rm, lu_mem_rd;
    logic        lu_ex, lu_mem;

    ctrl_state_e state_q, state_d;
    ctrl_state_e ret_q, ret_d;
    ctrl_state_e eff_state;
    logic [15:0] cnt_q, cnt_d;

    logic pc_ld_c, ifid_ld_c, pipe_en_c, nop_c, flush_c;

    forward_select u_fwd_rn (
        .src_i(ID_Bit19_16), .use_i(ID_use_rn),
        .ex_rd_i(EX_Bit15_12), .ex_we_i(EX_RF_Enable), .ex_load_i(EX_load_instr),
        .mem_rd_i(MEM_Bit15_12), .mem_we_i(MEM_RF_Enable), .mem_load_i(MEM_load_instr),
        .wb_rd_i(WB_Bit15_12), .wb_we_i(WB_RF_Enable),
        .sel_o(sel_rn), .lu_ex_o(lu_ex_rn), .lu_mem_o(lu_mem_rn)
    );

    forward_select u_fwd_rm (
        .src_i(ID_Bit3_0), .use_i(ID_use_rm),
        .ex_rd_i(EX_Bit15_12), .ex_we_i(EX_RF_Enable), .ex_load_i(EX_load_instr),
        .mem_rd_i(MEM_Bit15_12), .mem_we_i(MEM_RF_Enable), .mem_load_i(MEM_load_instr),
        .wb_rd_i(WB_Bit15_12), .wb_we_i(WB_RF_Enable),
        .sel_o(sel_rm), .lu_ex_o(lu_ex_rm), .lu_mem_o(lu_mem_rm)
    );

    forward_select u_fwd_rd (
        .src_i(ID_Bit15_12), .use_i(ID_use_rd),
        .ex_rd_i(EX_Bit15_12), .ex_we_i(EX_RF_Enable), .ex_load_i(EX_load_instr),
        .mem_rd_i(MEM_Bit15_12), .mem_we_i(MEM_RF_Enable), .mem_load_i(MEM_load_instr),
        .wb_rd_i(WB_Bit15_12), .wb_we_i(WB_RF_Enable),
        .sel_o(sel_rd), .lu_ex_o(lu_ex_rd), .lu_mem_o(lu_mem_rd)
    );

    assign lu_ex  = lu_ex_rn  | lu_ex_rm  | lu_ex_rd;
    assign lu_mem = lu_mem_rn | lu_mem_rm | lu_mem_rd;

    // Leaving FREEZE behaves as the saved state in the same cycle, so no stall is lost or repeated.
    assign eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        pc_ld_c   = 1'b1;
        ifid_ld_c = 1'b1;
        pipe_en_c = 1'b1;
        nop_c     = 1'b0;
        flush_c   = 1'b0;
        if (mem_busy) begin
            pc_ld_c   = 1'b0;
            ifid_ld_c = 1'b0;
            pipe_en_c = 1'b0;
            state_d   = ST_FREEZE;
            if (state_q != ST_FREEZE) begin
                ret_d = state_q;
            end
        end else begin
            case (eff_state)
                ST_LU_STALL: begin
                    pc_ld_c   = 1'b0;
                    ifid_ld_c = 1'b0;
                    nop_c     = 1'b1;
                    state_d   = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    if (lu_ex || lu_mem) begin
                        pc_ld_c   = 1'b0;
                        ifid_ld_c = 1'b0;
                        nop_c     = 1'b1;
                        if (lu_ex) begin
                            state_d = ST_LU_STALL;
                        end
                    end else if (branch_taken) begin
                        flush_c = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (!IF_ID_Load && (cnt_q != STALL_CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset forces the pipeline held with a NOP in ID/EX, independent of the clock.
    assign PC_RF_ld              = rst_n & pc_ld_c;
    assign IF_ID_Load            = rst_n & ifid_ld_c;
    assign pipe_en               = rst_n & pipe_en_c;
    assign MUXControlUnit_signal = ~rst_n | nop_c;
    assign IF_ID_flush           = rst_n & flush_c;
    assign MUX1_signal           = rst_n ? sel_rn : FWD_RF;
    assign MUX2_signal           = rst_n ? sel_rm : FWD_RF;
    assign MUX3_signal           = rst_n ? sel_rd : FWD_RF;
    assign stall_count           = cnt_q;

endmodule

// File: tb/tb_hazard_forwarding_controller.sv
// Directed bench for hazard_forwarding_controller: forwarding, load-use stalls,
// memory freeze, branch flush, counter saturation and asynchronous reset.
module tb_hazard_forwarding_controller;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ID_Bit19_16, ID_Bit3_0, ID_Bit15_12;
    logic        ID_use_rn, ID_use_rm, ID_use_rd;
    logic [3:0]  EX_Bit15_12, MEM_Bit15_12, WB_Bit15_12;
    logic        EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable;
    logic        EX_load_instr, MEM_load_instr;
    logic        branch_taken, mem_busy, clr_count;
    logic [1:0]  MUX1_signal, MUX2_signal, MUX3_signal;
    logic        PC_RF_ld, IF_ID_Load, pipe_en, MUXControlUnit_signal, IF_ID_flush;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    hazard_forwarding_controller dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Bit19_16(ID_Bit19_16), .ID_Bit3_0(ID_Bit3_0), .ID_Bit15_12(ID_Bit15_12),
        .ID_use_rn(ID_use_rn), .ID_use_rm(ID_use_rm), .ID_use_rd(ID_use_rd),
        .EX_Bit15_12(EX_Bit15_12), .MEM_Bit15_12(MEM_Bit15_12), .WB_Bit15_12(WB_Bit15_12),
        .EX_RF_Enable(EX_RF_Enable), .MEM_RF_Enable(MEM_RF_Enable), .WB_RF_Enable(WB_RF_Enable),
        .EX_load_instr(EX_load_instr), .MEM_load_instr(MEM_load_instr),
        .branch_taken(branch_taken), .mem_busy(mem_busy), .clr_count(clr_count),
        .MUX1_signal(MUX1_signal), .MUX2_signal(MUX2_signal), .MUX3_signal(MUX3_signal),
        .PC_RF_ld(PC_RF_ld), .IF_ID_Load(IF_ID_Load), .pipe_en(pipe_en),
        .MUXControlUnit_signal(MUXControlUnit_signal), .IF_ID_flush(IF_ID_flush),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ID_Bit19_16 = 4'd0; ID_Bit3_0 = 4'd0; ID_Bit15_12 = 4'd0;
        ID_use_rn = 1'b0; ID_use_rm = 1'b0; ID_use_rd = 1'b0;
        EX_Bit15_12 = 4'd0; MEM_Bit15_12 = 4'd0; WB_Bit15_12 = 4'd0;
        EX_RF_Enable = 1'b0; MEM_RF_Enable = 1'b0; WB_RF_Enable = 1'b0;
        EX_load_instr = 1'b0; MEM_load_instr = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0; clr_count = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_count();
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
    endtask

    // Packs {PC_RF_ld, IF_ID_Load, pipe_en, MUXControlUnit_signal, IF_ID_flush}.
    function automatic logic [4:0] ctl();
        return {PC_RF_ld, IF_ID_Load, pipe_en, MUXControlUnit_signal, IF_ID_flush};
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        ID_Bit19_16 = 4'd5; ID_use_rn = 1'b1; WB_Bit15_12 = 4'd5; WB_RF_Enable = 1'b1;
        #3;
        checks++;
        if (ctl() !== 5'b00010) begin
            errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), 5'b00010);
        end
        checks++;
        if (MUX1_signal !== 2'b00 || stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_mux_cnt got=%b/%h exp=00/0000", MUX1_signal, stall_count);
        end
        #4 rst_n = 1'b1;
        step();
        checks++;
        if (ctl() !== 5'b11100 || MUX1_signal !== 2'b11 || stall_count !== 16'd0) begin
            errors++; $display("FAIL post_reset got=%b/%b/%h exp=11100/11/0000", ctl(), MUX1_signal, stall_count);
        end
        idle();
    endtask

    task automatic test_forward();
        idle();
        ID_Bit19_16 = 4'd5; ID_use_rn = 1'b1; EX_Bit15_12 = 4'd5; EX_RF_Enable = 1'b1;
        #1; checks++;
        if (MUX1_signal !== 2'b01) begin errors++; $display("FAIL fwd_ex got=%b exp=01", MUX1_signal); end
        MEM_Bit15_12 = 4'd5; MEM_RF_Enable = 1'b1;
        #1; checks++;
        if (MUX1_signal !== 2'b01) begin errors++; $display("FAIL fwd_ex_over_mem got=%b exp=01", MUX1_signal); end
        EX_RF_Enable = 1'b0;
        #1; checks++;
        if (MUX1_signal !== 2'b10) begin errors++; $display("FAIL fwd_mem got=%b exp=10", MUX1_signal); end
        MEM_RF_Enable = 1'b0; WB_Bit15_12 = 4'd5; WB_RF_Enable = 1'b1;
        #1; checks++;
        if (MUX1_signal !== 2'b11) begin errors++; $display("FAIL fwd_wb got=%b exp=11", MUX1_signal); end
        ID_use_rn = 1'b0;
        #1; checks++;
        if (MUX1_signal !== 2'b00) begin errors++; $display("FAIL fwd_unused got=%b exp=00", MUX1_signal); end
        ID_Bit15_12 = 4'd9; ID_use_rd = 1'b1; MEM_Bit15_12 = 4'd9; MEM_RF_Enable = 1'b1;
        ID_Bit3_0 = 4'd9; ID_use_rm = 1'b1;
        #1; checks++;
        if (MUX3_signal !== 2'b10 || MUX2_signal !== 2'b10) begin
            errors++; $display("FAIL fwd_rd_rm got=%b/%b exp=10/10", MUX3_signal, MUX2_signal);
        end
        idle();
        step();
    endtask

    task automatic test_load_use();
        clear_count();
        EX_Bit15_12 = 4'd2; EX_RF_Enable = 1'b1; EX_load_instr = 1'b1;
        ID_Bit3_0 = 4'd2; ID_use_rm = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL lu_stall1 got=%b exp=00110", ctl()); end
        step();
        EX_RF_Enable = 1'b0; EX_load_instr = 1'b0; EX_Bit15_12 = 4'd0;
        MEM_Bit15_12 = 4'd2; MEM_RF_Enable = 1'b1; MEM_load_instr = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL lu_stall2 got=%b exp=00110", ctl()); end
        step();
        MEM_RF_Enable = 1'b0; MEM_load_instr = 1'b0; MEM_Bit15_12 = 4'd0;
        WB_Bit15_12 = 4'd2; WB_RF_Enable = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b11100 || MUX2_signal !== 2'b11 || stall_count !== 16'd2) begin
            errors++; $display("FAIL lu_resume got=%b/%b/%0d exp=11100/11/2", ctl(), MUX2_signal, stall_count);
        end
        idle();
        step();
    endtask

    task automatic test_lu_mem();
        clear_count();
        MEM_Bit15_12 = 4'd3; MEM_RF_Enable = 1'b1; MEM_load_instr = 1'b1;
        ID_Bit15_12 = 4'd3; ID_use_rd = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL lu_mem_stall got=%b exp=00110", ctl()); end
        step();
        MEM_RF_Enable = 1'b0; MEM_load_instr = 1'b0;
        WB_Bit15_12 = 4'd3; WB_RF_Enable = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b11100 || MUX3_signal !== 2'b11 || stall_count !== 16'd1) begin
            errors++; $display("FAIL lu_mem_resume got=%b/%b/%0d exp=11100/11/1", ctl(), MUX3_signal, stall_count);
        end
        idle();
        step();
    endtask

    task automatic test_freeze();
        clear_count();
        EX_Bit15_12 = 4'd2; EX_RF_Enable = 1'b1; EX_load_instr = 1'b1;
        ID_Bit3_0 = 4'd2; ID_use_rm = 1'b1;
        step();
        EX_RF_Enable = 1'b0; EX_load_instr = 1'b0; EX_Bit15_12 = 4'd0;
        MEM_Bit15_12 = 4'd2; MEM_RF_Enable = 1'b1; MEM_load_instr = 1'b1;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if (ctl() !== 5'b00000) begin errors++; $display("FAIL freeze_cycle%0d got=%b exp=00000", i, ctl()); end
            step();
        end
        mem_busy = 1'b0;
        #1; checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL freeze_remaining_stall got=%b exp=00110", ctl()); end
        step();
        MEM_RF_Enable = 1'b0; MEM_load_instr = 1'b0; MEM_Bit15_12 = 4'd0;
        WB_Bit15_12 = 4'd2; WB_RF_Enable = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b11100 || MUX2_signal !== 2'b11 || stall_count !== 16'd5) begin
            errors++; $display("FAIL freeze_resume got=%b/%b/%0d exp=11100/11/5", ctl(), MUX2_signal, stall_count);
        end
        idle();
        step();
    endtask

    task automatic test_branch();
        idle();
        branch_taken = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b11101) begin errors++; $display("FAIL br_flush got=%b exp=11101", ctl()); end
        step();
        branch_taken = 1'b0;
        #1; checks++;
        if (ctl() !== 5'b11100) begin errors++; $display("FAIL br_one_cycle got=%b exp=11100", ctl()); end
        branch_taken = 1'b1;
        EX_Bit15_12 = 4'd4; EX_RF_Enable = 1'b1; EX_load_instr = 1'b1;
        ID_Bit19_16 = 4'd4; ID_use_rn = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL br_vs_lu got=%b exp=00110", ctl()); end
        step();
        EX_RF_Enable = 1'b0; EX_load_instr = 1'b0;
        MEM_Bit15_12 = 4'd4; MEM_RF_Enable = 1'b1; MEM_load_instr = 1'b1;
        #1; checks++;
        if (ctl() !== 5'b00110) begin errors++; $display("FAIL br_in_stall got=%b exp=00110", ctl()); end
        step();
        idle();
        #1; checks++;
        if (ctl() !== 5'b11100) begin errors++; $display("FAIL br_after_stall got=%b exp=11100", ctl()); end
    endtask

    task automatic test_pc_and_saturation();
        idle();
        ID_Bit19_16 = 4'hF; ID_use_rn = 1'b1; WB_Bit15_12 = 4'hF; WB_RF_Enable = 1'b1;
        EX_Bit15_12 = 4'hF; EX_RF_Enable = 1'b1;
        #1; checks++;
        if (MUX1_signal !== 2'b00) begin errors++; $display("FAIL pc_no_fwd got=%b exp=00", MUX1_signal); end
        idle();
        clear_count();
        mem_busy = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        checks++;
        if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=ffff", stall_count); end
        step();
        checks++;
        if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_count); end
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        checks++;
        if (stall_count !== 16'd0) begin errors++; $display("FAIL clr_priority got=%h exp=0000", stall_count); end
        mem_busy = 1'b0;
        step();
        idle();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        EX_Bit15_12 = 4'd6; EX_RF_Enable = 1'b1; EX_load_instr = 1'b1;
        ID_Bit19_16 = 4'd6; ID_use_rn = 1'b1;
        step();
        EX_RF_Enable = 1'b0; EX_load_instr = 1'b0;
        WB_Bit15_12 = 4'd6; WB_RF_Enable = 1'b1;
        #2 rst_n = 1'b0;
        #1; checks++;
        if (ctl() !== 5'b00010 || MUX1_signal !== 2'b00 || stall_count !== 16'd0) begin
            errors++; $display("FAIL rst_mid_stall got=%b/%b/%h exp=00010/00/0000", ctl(), MUX1_signal, stall_count);
        end
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (ctl() !== 5'b11100 || MUX1_signal !== 2'b11 || stall_count !== 16'd0) begin
            errors++; $display("FAIL rst_release_run got=%b/%b/%h exp=11100/11/0000", ctl(), MUX1_signal, stall_count);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_lu_mem();
        test_freeze();
        test_branch();
        test_pc_and_saturation();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
